// File: rtl/ifetch32_if.sv
// Fetch-stage bundle: instruction-memory read channel plus the decode-side
// instruction/branch/link signals.
interface ifetch32_if #(
    parameter int FULLW = 32
);
    logic             imem_req_out;
    logic [FULLW-1:0] imem_addr_out;
    logic [FULLW-1:0] imem_rdata_in;
    logic             imem_rvalid_in;
    logic [FULLW-1:0] i_out;
    logic [FULLW-1:0] pc_out;
    logic             i_valid_out;
    logic             stall_in;
    logic             ib_in;
    logic [FULLW-1:0] bv_in;
    logic             bl_in;
    logic             lr_we_out;
    logic [FULLW-1:0] lr_out;

    modport master (
        output imem_req_out, imem_addr_out, i_out, pc_out, i_valid_out, lr_we_out, lr_out,
        input  imem_rdata_in, imem_rvalid_in, stall_in, ib_in, bv_in, bl_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, i_out, pc_out, i_valid_out, lr_we_out, lr_out,
        output imem_rdata_in, imem_rvalid_in, stall_in, ib_in, bv_in, bl_in
    );
endinterface

// File: rtl/ifetch32.sv
// Instruction fetch: PC, single-outstanding imem reads, one output slot plus a
// one-entry skid buffer, branch redirect/flush and link-register write.
//
// state | meaning
// IDLE  | no read in flight
// WAIT  | read in flight, its response will be kept
// DROP  | read in flight, its response belongs to a flushed path
module ifetch32 #(
    parameter int               FULLW    = 32,
    parameter logic [FULLW-1:0] RESET_PC = '0
) (
    input logic        clk,
    input logic        rst_n,
    ifetch32_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} req_state_t;

    req_state_t       state, state_n;
    logic             active;
    logic [FULLW-1:0] fpc, req_pc, addr, target;
    logic [FULLW-1:0] i_q, pc_q, skid_i, skid_pc, lr_q;
    logic             i_valid_q, skid_valid, lr_we_q;
    logic             xfer, branch, resp, resp_keep, req;

    always_comb begin
        xfer      = i_valid_q & ~bus.stall_in;
        branch    = xfer & bus.ib_in;
        resp      = bus.imem_rvalid_in & (state != IDLE);
        resp_keep = bus.imem_rvalid_in & (state == WAIT) & ~branch;
        target    = pc_q + FULLW'(8) + (bus.bv_in & ~FULLW'(3));
        addr      = branch ? target : fpc;
        req       = 1'b0;
        // A branch flushes the slot and skid, so the target may issue regardless
        // of occupancy; otherwise never issue a read that would have no landing slot.
        if (active && state != DROP && (state == IDLE || bus.imem_rvalid_in)) begin
            if (branch)
                req = 1'b1;
            else
                req = ~skid_valid & ~(i_valid_q & ~xfer & resp_keep);
        end
        state_n = state;
        if (req)
            state_n = WAIT;
        else if (branch && state == WAIT && !bus.imem_rvalid_in)
            state_n = DROP;
        else if (resp)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active     <= 1'b0;
            fpc        <= RESET_PC;
            req_pc     <= '0;
            i_valid_q  <= 1'b0;
            i_q        <= '0;
            pc_q       <= '0;
            skid_valid <= 1'b0;
            skid_i     <= '0;
            skid_pc    <= '0;
            lr_we_q    <= 1'b0;
            lr_q       <= '0;
        end else begin
            active <= 1'b1;
            if (req) begin
                fpc    <= addr + FULLW'(4);
                req_pc <= addr;
            end else if (branch) begin
                fpc <= target;
            end
            lr_we_q <= branch & bus.bl_in;
            if (branch && bus.bl_in)
                lr_q <= pc_q + FULLW'(4);
            if (branch) begin
                i_valid_q  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!i_valid_q || xfer) begin
                if (skid_valid) begin
                    i_q        <= skid_i;
                    pc_q       <= skid_pc;
                    i_valid_q  <= 1'b1;
                    skid_valid <= resp_keep;
                    if (resp_keep) begin
                        skid_i  <= bus.imem_rdata_in;
                        skid_pc <= req_pc;
                    end
                end else if (resp_keep) begin
                    i_q       <= bus.imem_rdata_in;
                    pc_q      <= req_pc;
                    i_valid_q <= 1'b1;
                end else begin
                    i_valid_q <= 1'b0;
                end
            end else if (resp_keep) begin
                skid_i     <= bus.imem_rdata_in;
                skid_pc    <= req_pc;
                skid_valid <= 1'b1;
            end
        end
    end

    assign bus.imem_req_out  = req;
    assign bus.imem_addr_out = addr;
    assign bus.i_out         = i_q;
    assign bus.pc_out        = pc_q;
    assign bus.i_valid_out   = i_valid_q;
    assign bus.lr_we_out     = lr_we_q;
    assign bus.lr_out        = lr_q;
endmodule

// File: tb/tb_ifetch32.sv
// Bench for ifetch32: word=address memory models, a program-order model of
// what decode must see, and directed scenarios with literal expectations.
module tb_ifetch32;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ifetch32_if #(.FULLW(W)) bus0 ();
    ifetch32_if #(.FULLW(W)) bus1 ();

    ifetch32 #(.FULLW(W), .RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    ifetch32 #(.FULLW(W), .RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    typedef struct { int c; logic [31:0] a; } mreq_t;
    mreq_t       q0[$], q1[$];
    logic [31:0] req0_addr[$], req0_cyc[$], req1_addr[$], xfer0[$], xfer1[$];
    int          cyc = 0, lat = 1, n_total = 0, n_pass = 0, first_valid = -1;

    // program-order model of dut0
    logic [31:0] m_exp_pc, m_lr_val, m_lr_hold;
    bit          m_lr_due, m_flush, m_outst, m_prev_valid, m_prev_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic model_reset();
        m_exp_pc = 32'h0; m_lr_val = 32'h0; m_lr_hold = 32'h0;
        m_lr_due = 0; m_flush = 0; m_outst = 0; m_prev_valid = 0; m_prev_stall = 0;
    endtask

    task automatic drive_mem();
        mreq_t m;
        if (q0.size() > 0 && q0[0].c + lat <= cyc) begin
            m = q0.pop_front();
            bus0.imem_rvalid_in = 1'b1; bus0.imem_rdata_in = m.a;
        end else begin
            bus0.imem_rvalid_in = 1'b0; bus0.imem_rdata_in = '0;
        end
        if (q1.size() > 0 && q1[0].c + 1 <= cyc) begin
            m = q1.pop_front();
            bus1.imem_rvalid_in = 1'b1; bus1.imem_rdata_in = m.a;
        end else begin
            bus1.imem_rvalid_in = 1'b0; bus1.imem_rdata_in = '0;
        end
    endtask

    task automatic compare_cycle();
        bit xfer;
        if (bus0.imem_req_out) begin
            check("one_outstanding", {31'b0, (!m_outst || bus0.imem_rvalid_in)}, 32'd1);
            check("addr_align", {30'b0, bus0.imem_addr_out[1:0]}, 32'd0);
        end
        if (m_flush) check("flush_valid", {31'b0, bus0.i_valid_out}, 32'd0);
        if (m_prev_valid && m_prev_stall) check("stall_valid_hold", {31'b0, bus0.i_valid_out}, 32'd1);
        if (bus0.i_valid_out) begin
            check("pc_order", bus0.pc_out, m_exp_pc);
            check("instr", bus0.i_out, m_exp_pc);
            if (first_valid < 0) first_valid = cyc;
        end
        check("lr_we", {31'b0, bus0.lr_we_out}, {31'b0, m_lr_due});
        check("lr_out", bus0.lr_out, m_lr_due ? m_lr_val : m_lr_hold);

        if (m_lr_due) m_lr_hold = m_lr_val;
        m_lr_due = 0;
        m_flush  = 0;
        xfer = bus0.i_valid_out && !bus0.stall_in;
        if (xfer) begin
            xfer0.push_back(bus0.pc_out);
            if (bus0.ib_in) begin
                if (bus0.bl_in) begin m_lr_due = 1; m_lr_val = m_exp_pc + 32'd4; end
                m_exp_pc = m_exp_pc + 32'd8 + {bus0.bv_in[31:2], 2'b00};
                m_flush  = 1;
            end else begin
                m_exp_pc = m_exp_pc + 32'd4;
            end
        end
        if (bus0.imem_req_out) m_outst = 1;
        else if (bus0.imem_rvalid_in) m_outst = 0;
        m_prev_valid = bus0.i_valid_out;
        m_prev_stall = bus0.stall_in;
        if (bus1.i_valid_out) xfer1.push_back(bus1.pc_out);
    endtask

    task automatic tick();
        drive_mem();
        #1;
        compare_cycle();
        if (bus0.imem_req_out) begin
            q0.push_back('{c: cyc, a: bus0.imem_addr_out});
            req0_addr.push_back(bus0.imem_addr_out);
            req0_cyc.push_back(cyc);
        end
        if (bus1.imem_req_out) begin
            q1.push_back('{c: cyc, a: bus1.imem_addr_out});
            req1_addr.push_back(bus1.imem_addr_out);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input string name, input bit any_pc, input logic [31:0] pc, input bit need_wait);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus0.i_valid_out === 1'b1 && (any_pc || bus0.pc_out === pc) &&
                (!need_wait || (q0.size() > 0 && q0[0].c + lat > cyc))) begin
                found = 1;
                break;
            end
            tick();
        end
        check(name, {31'b0, found}, 32'd1);
    endtask

    initial begin
        int n, b, xn;
        bus0.stall_in = 0; bus0.ib_in = 0; bus0.bl_in = 0; bus0.bv_in = '0;
        bus0.imem_rvalid_in = 0; bus0.imem_rdata_in = '0;
        bus1.stall_in = 0; bus1.ib_in = 0; bus1.bl_in = 0; bus1.bv_in = '0;
        bus1.imem_rvalid_in = 0; bus1.imem_rdata_in = '0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_i_valid", {31'b0, bus0.i_valid_out}, 32'd0);
        check("rst_i_out", bus0.i_out, 32'd0);
        check("rst_pc_out", bus0.pc_out, 32'd0);
        check("rst_req", {31'b0, bus0.imem_req_out}, 32'd0);
        check("rst_lr_we", {31'b0, bus0.lr_we_out}, 32'd0);
        check("rst_lr_out", bus0.lr_out, 32'd0);
        rst_n = 1'b1;

        // sequential fetch, 1-cycle memory
        repeat (10) tick();
        check("seq_req0", at(req0_addr, 0), 32'h0);
        check("seq_req1", at(req0_addr, 1), 32'h4);
        check("seq_req2", at(req0_addr, 2), 32'h8);
        check("seq_req_gap1", at(req0_cyc, 1) - at(req0_cyc, 0), 32'd1);
        check("seq_req_gap2", at(req0_cyc, 2) - at(req0_cyc, 1), 32'd1);
        check("seq_first_valid_lat", first_valid - int'(at(req0_cyc, 0)), 32'd2);
        check("seq_pc0", at(xfer0, 0), 32'h0);
        check("seq_pc1", at(xfer0, 1), 32'h4);
        check("seq_pc2", at(xfer0, 2), 32'h8);
        check("wrap_req0", at(req1_addr, 0), 32'hFFFF_FFF8);
        check("wrap_req1", at(req1_addr, 1), 32'hFFFF_FFFC);
        check("wrap_req2", at(req1_addr, 2), 32'h0000_0000);
        check("wrap_pc0", at(xfer1, 0), 32'hFFFF_FFF8);
        check("wrap_pc1", at(xfer1, 1), 32'hFFFF_FFFC);
        check("wrap_pc2", at(xfer1, 2), 32'h0000_0000);

        // 3-cycle stall with a response in flight
        n = req0_addr.size();
        bus0.stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            check("stall_pc", bus0.pc_out, 32'h1C);
            tick();
        end
        bus0.stall_in = 0;
        check("stall_no_req", req0_addr.size() - n, 32'd0);
        repeat (4) tick();
        check("stall_xfer0", at(xfer0, 7), 32'h1C);
        check("stall_xfer1", at(xfer0, 8), 32'h20);
        check("stall_xfer2", at(xfer0, 9), 32'h24);

        // BL at 0x40, offset -16
        run_until("bl_reach", 0, 32'h40, 0);
        n = req0_addr.size(); b = cyc;
        bus0.ib_in = 1; bus0.bl_in = 1; bus0.bv_in = 32'hFFFF_FFF0;
        tick();
        bus0.ib_in = 0; bus0.bl_in = 0; bus0.bv_in = '0;
        check("bl_target_req", at(req0_addr, n), 32'h38);
        check("bl_target_cyc", at(req0_cyc, n), b);
        check("bl_lr_we", {31'b0, bus0.lr_we_out}, 32'd1);
        check("bl_lr_out", bus0.lr_out, 32'h44);
        check("bl_flush", {31'b0, bus0.i_valid_out}, 32'd0);
        tick();
        check("bl_lr_we_end", {31'b0, bus0.lr_we_out}, 32'd0);
        check("bl_lr_hold", bus0.lr_out, 32'h44);
        check("bl_target_pc", bus0.pc_out, 32'h38);

        // branch at 0x100, offset 0x20
        run_until("br_reach", 0, 32'h100, 0);
        n = req0_addr.size(); b = cyc;
        bus0.ib_in = 1; bus0.bv_in = 32'h20;
        tick();
        bus0.ib_in = 0; bus0.bv_in = '0;
        check("br_target_req", at(req0_addr, n), 32'h128);
        check("br_target_cyc", at(req0_cyc, n), b);
        check("br_flush", {31'b0, bus0.i_valid_out}, 32'd0);
        tick();
        check("br_target_valid", {31'b0, bus0.i_valid_out}, 32'd1);
        check("br_target_pc", bus0.pc_out, 32'h128);

        // 3-cycle memory, branch while a read is outstanding
        lat = 3;
        run_until("drop_reach", 0, 32'h140, 1);
        n = req0_addr.size(); b = cyc;
        bus0.ib_in = 1; bus0.bv_in = 32'h100;
        tick();
        bus0.ib_in = 0; bus0.bv_in = '0;
        check("drop_no_req_in_branch", req0_addr.size() - n, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            check("drop_valid_low", {31'b0, bus0.i_valid_out}, 32'd0);
            tick();
        end
        check("drop_target_valid", {31'b0, bus0.i_valid_out}, 32'd1);
        check("drop_target_pc", bus0.pc_out, 32'h248);
        check("drop_target_req", at(req0_addr, n), 32'h248);
        check("drop_target_cyc", at(req0_cyc, n), b + 3);

        // async reset while a read is in flight
        run_until("rst_reach", 1, 32'h0, 1);
        bus0.imem_rvalid_in = 0; bus1.imem_rvalid_in = 0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_i_valid", {31'b0, bus0.i_valid_out}, 32'd0);
        check("arst_i_out", bus0.i_out, 32'd0);
        check("arst_pc_out", bus0.pc_out, 32'd0);
        check("arst_req", {31'b0, bus0.imem_req_out}, 32'd0);
        check("arst_lr_we", {31'b0, bus0.lr_we_out}, 32'd0);
        check("arst_lr_out", bus0.lr_out, 32'd0);
        model_reset();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        n = req0_addr.size(); xn = xfer0.size();
        repeat (2) tick();
        check("arst_stale_ignored", {31'b0, bus0.i_valid_out}, 32'd0);
        repeat (4) tick();
        check("arst_restart_req", at(req0_addr, n), 32'h0);
        check("arst_restart_pc", at(xfer0, xn), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ifetch32.md
Name: ifetch32

Overview:
- Instruction fetch stage feeding the 32-bit instruction decoder.
- Holds the program counter and issues word reads to instruction memory (one outstanding request).
- Presents fetched instructions to decode with valid/stall flow control.
- Consumes decode's branch outputs (branch taken, branch offset, branch-link) to redirect the PC and flush wrong-path instructions.
- Drives the link-register write for BL.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] must be 0.
FULLW, 32, instruction, address and data width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
imem_req_out  output  1  request strobe; one-cycle pulse per read.
imem_addr_out  output  FULLW  word-aligned read address; valid while imem_req_out=1.
imem_rdata_in  input  FULLW  read data; valid while imem_rvalid_in=1.
imem_rvalid_in  input  1  response strobe; arrives ≥1 cycle after its request, in order.
i_out  output  FULLW  instruction presented to decode.
pc_out  output  FULLW  address of i_out.
i_valid_out  output  1  i_out/pc_out valid.
stall_in  input  1  decode not ready; the instruction on i_out is held.
ib_in  input  1  branch taken for the instruction on i_out; sampled only when i_valid_out=1 and stall_in=0.
bv_in  input  FULLW  sign-extended byte offset (already <<2); bits [1:0] ignored.
bl_in  input  1  branch-with-link; qualified by ib_in.
lr_we_out  output  1  link-register write enable (one-cycle pulse).
lr_out  output  FULLW  link value.

Behaviour:
- Reset (async assert):
  - fpc=RESET_PC; i_valid_out=0; i_out=0; pc_out=0; imem_req_out=0; lr_we_out=0; lr_out=0.
  - Skid buffer empty; outstanding=0; discard=0.
  - Any imem_rvalid_in while outstanding=0 is ignored. This also covers responses to requests issued before a mid-operation reset.
- States (implicit in outstanding/discard/skid flags):
  - IDLE: no request in flight.
  - WAIT: request in flight, response kept.
  - DROP: request in flight, response discarded.
- Transfer: the output slot is consumed when i_valid_out=1 and stall_in=0.
- Request issue (combinational imem_req_out):
  - Issue when the skid buffer is empty, discard=0, and either outstanding=0 or imem_rvalid_in=1 this cycle.
  - Do not issue if the output slot is full, not consumed, and the response would land in the skid buffer.
  - imem_addr_out=fpc. On issue, fpc<=fpc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
- Response handling (imem_rvalid_in with outstanding=1, discard=0):
  - If the output slot is empty or consumed this cycle, load i_out/pc_out and set i_valid_out=1 at the next edge. Latency is rvalid cycle N → i_valid_out in cycle N+1.
  - Otherwise write the skid buffer (1 entry).
  - Each entry tags its own PC.
- Skid drain: when the output slot is consumed and the skid buffer is full, the skid entry moves to the output the next cycle. A simultaneous memory response goes into the skid buffer.
- Throughput: 1 instruction/cycle with 1-cycle memory and no stalls.
- Branch (ib_in=1 at a transfer):
  - fpc<=pc_out+8+{bv_in[31:2],2'b00}, modulo 2^32.
  - Next cycle: i_valid_out=0 and the skid buffer is cleared.
  - If a request is outstanding and its response is not arriving this cycle, set discard=1 (DROP). The next response is dropped, then discard clears.
  - If the response arrives in the branch cycle, drop it and issue the target request in that same cycle; otherwise the target request issues the cycle after the drop.
  - No wrong-path instruction may reach i_valid_out=1.
- Link: if bl_in & ib_in at a transfer, then next cycle lr_we_out=1 and lr_out=pc_out+4 of the branch instruction. Otherwise lr_we_out=0 and lr_out holds its value.
- ib_in/bl_in outside a transfer: no effect.
- Stall: i_out/pc_out/i_valid_out remain stable while stall_in=1.

Test Plan:
- Reset release, 1-cycle memory returning word = address: requests 0x0,0x4,0x8 on consecutive cycles; i_valid_out first high 2 cycles after the first request; pc_out 0x0,0x4,0x8 back-to-back.
- stall_in high for 3 cycles while a response is in flight: skid buffer fills and no further request issues; pc_out holds; after release pc_out increments by 4 with no gap and no lost or duplicated instruction.
- Branch at pc_out=0x100 with bv_in=0x20, bl_in=0: next request address 0x128; wrong-path 0x104/0x108 never valid; i_valid_out low until the 0x128 response arrives.
- BL at pc_out=0x40, bv_in=0xFFFFFFF0: target 0x38; lr_we_out pulses one cycle with lr_out=0x44.
- 3-cycle memory latency, branch while a request is outstanding: that response is dropped; target request issues the cycle after the drop; only target instructions become valid.
- RESET_PC=0xFFFFFFF8 sequential run: requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Async rst_n assert mid-WAIT: all outputs go to reset values immediately (without a clock edge); a stale rvalid arriving after reset is ignored; fetch restarts at RESET_PC.
